// File: rtl/sr_seq_module_if.sv
// Request/result bundle for the sequential shift-right unit.
interface sr_seq_module_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
);
  logic             start;
  logic [WIDTH-1:0] inp;
  logic [SHW-1:0]   shamt;
  logic             arith;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;

  // Requester side
  modport master (
    output start, inp, shamt, arith,
    input  out, busy, done
  );

  // Shifter side
  modport slave (
    input  start, inp, shamt, arith,
    output out, busy, done
  );
endinterface

// File: rtl/sr_seq_module.sv
// Sequential 32-bit right shifter: one binary-weighted stage (1, 2, 4, 8, 16) per clock,
// logical or arithmetic fill, start/busy/done handshake, fixed 5-cycle latency.
module sr_seq_module #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5    // log2(WIDTH); also the number of stages
) (
  input  logic            clk,
  input  logic            reset,
  sr_seq_module_if.slave  bus
);

  localparam int unsigned StW = $clog2(SHW);

  typedef enum logic [1:0] {StIdle, StShift, StFin} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   amt_q;
  logic             fill_q;
  logic [StW-1:0]   stage_q;
  logic [WIDTH-1:0] out_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] shifted;
  logic [SHW:0]     sh;
  logic [SHW:0]     idx;
  logic             last_stage;

  assign last_stage = (stage_q == StW'(SHW - 1));

  // One stage of the shift: bit i takes work[i + 2^stage], or the fill bit once that index
  // runs past the top (idx[SHW] set, since WIDTH == 2**SHW). A 2:1 mux per bit picks it.
  always_comb begin
    shifted = '0;
    idx     = '0;
    sh      = (SHW + 1)'(1) << stage_q;
    for (int i = 0; i < WIDTH; i++) begin
      idx        = (SHW + 1)'(i) + sh;
      shifted[i] = idx[SHW] ? fill_q : work_q[idx[SHW-1:0]];
    end
    work_d = amt_q[stage_q] ? shifted : work_q;
  end

  // Control FSM with registered outputs; an accept in StFin gives back-to-back operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      work_q  <= '0;
      amt_q   <= '0;
      fill_q  <= 1'b0;
      stage_q <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StFin: begin
          done_q <= 1'b0;
          if (bus.start) begin
            work_q  <= bus.inp;
            amt_q   <= bus.shamt;
            fill_q  <= bus.arith & bus.inp[WIDTH-1];
            stage_q <= '0;
            busy_q  <= 1'b1;
            state_q <= StShift;
          end else begin
            state_q <= StIdle;
          end
        end
        StShift: begin
          work_q  <= work_d;
          stage_q <= stage_q + 1'b1;
          if (last_stage) begin
            out_q   <= work_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StFin;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_sr_seq_module.sv
// Directed self-checking bench for sr_seq_module.
module tb_sr_seq_module;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  sr_seq_module_if #(.WIDTH(32), .SHW(5)) bus ();

  sr_seq_module #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a request while positioned just after an edge; returns just after the accept edge.
  task automatic start_op(input logic [31:0] a, input logic [4:0] s, input logic ar);
    bus.inp   = a;
    bus.shamt = s;
    bus.arith = ar;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Bounded wait for done; lat = edges after accept (-1 on timeout).
  task automatic wait_done(output int lat, output bit busy_ok);
    lat     = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = k;
        if (bus.busy) busy_ok = 1'b0;
        break;
      end else if (!bus.busy) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.inp   = '0;
    bus.shamt = '0;
    bus.arith = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if (bus.out !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: out=%h busy=%b done=%b, want out=0 busy=0 done=0",
               bus.out, bus.busy, bus.done);
    end
  endtask

  task automatic test_basic_logical();
    int lat;
    bit bok;
    start_op(32'hF000_0000, 5'd4, 1'b0);
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_after_accept: busy=%b want 1", bus.busy);
    end
    wait_done(lat, bok);
    n_checks++;
    if (lat !== 5) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d want 5", lat);
    end
    n_checks++;
    if (bok !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_profile: busy not high for 5 cycles / low at done");
    end
    n_checks++;
    if (bus.out !== 32'h0F00_0000) begin
      n_fail++;
      $display("FAIL basic_out: got %h want 0f000000", bus.out);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.done !== 1'b0 || bus.out !== 32'h0F00_0000) begin
      n_fail++;
      $display("FAIL basic_done_pulse: done=%b out=%h want done=0 out=0f000000",
               bus.done, bus.out);
    end
  endtask

  task automatic test_arith();
    logic [31:0] a [3];
    logic [4:0]  s [3];
    logic        ar[3];
    logic [31:0] exp_v[3];
    int lat;
    bit bok;
    a[0] = 32'hF000_0000; s[0] = 5'd4;  ar[0] = 1'b1; exp_v[0] = 32'hFF00_0000;
    a[1] = 32'h8000_0001; s[1] = 5'd31; ar[1] = 1'b1; exp_v[1] = 32'hFFFF_FFFF;
    a[2] = 32'h8000_0001; s[2] = 5'd31; ar[2] = 1'b0; exp_v[2] = 32'h0000_0001;
    for (int i = 0; i < 3; i++) begin
      start_op(a[i], s[i], ar[i]);
      wait_done(lat, bok);
      n_checks++;
      if (lat !== 5 || bus.out !== exp_v[i]) begin
        n_fail++;
        $display("FAIL arith_vec%0d: out=%h lat=%0d want out=%h lat=5", i, bus.out, lat, exp_v[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_sweep();
    logic [31:0] x;
    logic [31:0] exp_v;
    int lat;
    bit bok;
    start_op(32'h1234_5678, 5'd0, 1'b1);
    wait_done(lat, bok);
    n_checks++;
    if (lat !== 5 || bus.out !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL shamt0: out=%h lat=%0d want out=12345678 lat=5", bus.out, lat);
    end
    @(posedge clk);
    #1;
    x = 32'hDEAD_BEEF;
    for (int m = 0; m < 2; m++) begin
      for (int s = 1; s < 32; s++) begin
        if (m == 1) exp_v = $signed(x) >>> s;
        else        exp_v = x >> s;
        start_op(x, 5'(s), m[0]);
        wait_done(lat, bok);
        n_checks++;
        if (lat !== 5 || bus.out !== exp_v) begin
          n_fail++;
          $display("FAIL sweep arith=%0d shamt=%0d: out=%h lat=%0d want out=%h lat=5",
                   m, s, bus.out, lat, exp_v);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_start_while_busy();
    int dones;
    start_op(32'hF000_0000, 5'd4, 1'b0);
    @(posedge clk);
    #1;
    bus.inp   = 32'hFFFF_FFFF;
    bus.shamt = 5'd1;
    bus.arith = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.inp   = 32'h0000_0000;
    dones = 0;
    for (int k = 0; k < 14; k++) begin
      if (bus.done) begin
        dones++;
        n_checks++;
        if (bus.out !== 32'h0F00_0000) begin
          n_fail++;
          $display("FAIL busy_ignore_out: got %h want 0f000000", bus.out);
        end
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL busy_ignore_done_count: got %0d want 1", dones);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit bok;
    bit hold_ok;
    start_op(32'h8000_0000, 5'd1, 1'b0);
    wait_done(lat, bok);
    n_checks++;
    if (lat !== 5 || bus.out !== 32'h4000_0000) begin
      n_fail++;
      $display("FAIL b2b_first: out=%h lat=%0d want out=40000000 lat=5", bus.out, lat);
    end
    // Request in the done cycle
    start_op(32'h0000_FF00, 5'd8, 1'b0);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.out !== 32'h4000_0000) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b done=%b out=%h want busy=1 done=0 out=40000000",
               bus.busy, bus.done, bus.out);
    end
    hold_ok = 1'b1;
    lat     = -1;
    for (int k = 2; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.out !== 32'h4000_0000) hold_ok = 1'b0;
    end
    n_checks++;
    if (lat !== 6) begin
      n_fail++;
      $display("FAIL b2b_spacing: done pulses %0d cycles apart, want 6", lat);
    end
    n_checks++;
    if (hold_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_hold: out changed before second completion");
    end
    n_checks++;
    if (bus.out !== 32'h0000_00FF) begin
      n_fail++;
      $display("FAIL b2b_second: got %h want 000000ff", bus.out);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_op();
    int dones;
    int lat;
    bit bok;
    start_op(32'hFFFF_0000, 5'd3, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset: busy=%b done=%b out=%h want busy=0 done=0 out=0",
               bus.busy, bus.done, bus.out);
    end
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL midreset_quiet: %0d cycles with busy/done after abort, want 0", dones);
    end
    start_op(32'h1234_5678, 5'd4, 1'b0);
    wait_done(lat, bok);
    n_checks++;
    if (lat !== 5 || bus.out !== 32'h0123_4567) begin
      n_fail++;
      $display("FAIL after_reset_op: out=%h lat=%0d want out=01234567 lat=5", bus.out, lat);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_logical();
    test_arith();
    test_sweep();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
